// File: rtl/sample_serializer.sv
`default_nettype none
// sample_serializer: fetches DDS samples and streams each one as a mono L/R DAC frame.
// Left-justified by default; define I2S_DELAY_EN for one-bit-delayed I2S data.
module sample_serializer #(
  parameter int N        = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] sample,
  input  logic         new_sample_ready,
  output logic         sampling_pulse,
  output logic         bclk,
  output logic         lrck,
  output logic         sdata,
  output logic         underrun,
  output logic         overrun
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * N);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * N - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   holding;
  logic [2*N-1:0] shift;
  logic [DW-1:0]  div_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [BW-1:0]  bit_inc;
  logic           fresh;
  logic           enter;
  logic           leave;
  logic           bit_fall;
  logic           frame_wrap;
  logic           frame_start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    enter      = 1'b0;
    leave      = 1'b0;
    bit_fall   = 1'b0;
    frame_wrap = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = RUN;
          enter      = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = IDLE;
          leave      = 1'b1;
        end else if (div_cnt == DIV_LAST && bclk) begin
          bit_fall   = 1'b1;
          frame_wrap = (bit_cnt == BIT_LAST);
        end
      end
      default: state_next = IDLE;
    endcase
    frame_start = enter | frame_wrap;
  end

  assign bit_inc = bit_cnt + BW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      holding        <= '0;
      shift          <= '0;
      fresh          <= 1'b0;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      bclk           <= 1'b0;
      lrck           <= 1'b0;
      sampling_pulse <= 1'b0;
      underrun       <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      sampling_pulse <= frame_start;
      // The first frame after RUN entry is never an underrun.
      underrun       <= frame_wrap & ~fresh;
      overrun        <= new_sample_ready & fresh & ~frame_start;

      // A capture on a frame-start edge survives for the next frame.
      if (new_sample_ready) begin
        holding <= sample;
        fresh   <= 1'b1;
      end else if (frame_start) begin
        fresh   <= 1'b0;
      end

      if (frame_start)   shift <= {holding, holding};
      else if (bit_fall) shift <= {shift[2*N-2:0], 1'b0};
      else if (leave)    shift <= '0;

      if (state == IDLE || leave) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk    <= 1'b0;
        lrck    <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
        if (bit_fall) begin
          bit_cnt <= frame_wrap ? '0 : bit_inc;
          lrck    <= frame_wrap ? 1'b0 : (bit_inc >= BIT_HALF);
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

`ifdef I2S_DELAY_EN
  logic sdata_dly;

  always_ff @(posedge clk) begin
    if (reset || state == IDLE || leave) sdata_dly <= 1'b0;
    else if (bit_fall)                   sdata_dly <= shift[2*N-1];
  end

  assign sdata = sdata_dly;
`else
  assign sdata = shift[2*N-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_serializer.sv
`default_nettype none
// Bench for sample_serializer: frame-level reference model checked every cycle,
// directed frames with literal expectations, then randomized strobes/enable/reset.
module tb_sample_serializer;

  localparam int N     = 16;
  localparam int BD    = 4;
  localparam int FRAME = 4 * N * BD;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         nsr = 1'b0;
  logic [N-1:0] sample = '0;
  logic         sampling_pulse, bclk, lrck, sdata, underrun, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_serializer #(.N(N), .BCLK_DIV(BD)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .sample          (sample),
    .new_sample_ready(nsr),
    .sampling_pulse  (sampling_pulse),
    .bclk            (bclk),
    .lrck            (lrck),
    .sdata           (sdata),
    .underrun        (underrun),
    .overrun         (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position inside the frame derived from cycles since RUN entry.
  bit           m_valid = 0;
  bit           m_run = 0;
  int           m_k = 0;
  logic [N-1:0] m_hold = '0;
  logic [N-1:0] m_word = '0;
  bit           m_fresh = 0;
  bit           m_prev = 0;
  bit           e_sp = 0, e_ur = 0, e_ov = 0;

  function automatic logic [31:0] model_outputs();
    int   b;
    logic e_bclk, e_lr, e_sd;
    e_bclk = 1'b0;
    e_lr   = 1'b0;
    e_sd   = 1'b0;
    if (m_run) begin
      b      = (m_k / (2 * BD)) % (2 * N);
      e_bclk = ((m_k / BD) % 2) == 1;
      e_lr   = (b >= N);
`ifdef I2S_DELAY_EN
      e_sd   = (b == 0) ? m_prev : m_word[N-1-((b-1) % N)];
`else
      e_sd   = m_word[N-1-(b % N)];
`endif
    end
    return {26'd0, e_sp, e_bclk, e_lr, e_sd, e_ur, e_ov};
  endfunction

  always @(posedge clk) begin : model
    bit fs, wrap;
    fs   = 0;
    wrap = 0;
    if (reset) begin
      m_valid = 1; m_run = 0; m_k = 0; m_hold = '0; m_word = '0;
      m_fresh = 0; m_prev = 0; e_sp = 0; e_ur = 0; e_ov = 0;
    end else begin
      if (!m_run && enable) begin
        m_run = 1; m_k = 0; fs = 1;
      end else if (m_run && !enable) begin
        m_run = 0;
      end else if (m_run) begin
        m_k++;
        wrap = (m_k % FRAME) == 0;
        fs   = wrap;
      end
      e_sp = fs;
      e_ur = wrap && !m_fresh;
      e_ov = nsr && m_fresh && !fs;
      if (fs) begin
        m_prev = wrap ? m_word[0] : 1'b0;
        m_word = m_hold;
      end
      if (nsr) begin
        m_hold  = sample;
        m_fresh = 1;
      end else if (fs) begin
        m_fresh = 0;
      end
    end
    #1;
    if (m_valid)
      check("outputs{sp,bclk,lrck,sdata,ur,ov}",
            {26'd0, sampling_pulse, bclk, lrck, sdata, underrun, overrun}, model_outputs());
  end

  // Runs one frame; the next negedge must be cycle 0 of the frame.
  task automatic run_frame(input int s1, input logic [N-1:0] v1,
                           input int s2, input logic [N-1:0] v2,
                           output logic [31:0] bits, output int sp, output int sp0,
                           output int ur, output int ov, output int lrlow);
    logic pb;
    pb = 1'b0; bits = '0; sp = 0; sp0 = 0; ur = 0; ov = 0; lrlow = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (bclk && !pb) bits = {bits[30:0], sdata};
      pb = bclk;
      sp += int'(sampling_pulse);
      ur += int'(underrun);
      ov += int'(overrun);
      lrlow += int'(!lrck);
      if (c == 0) sp0 = int'(sampling_pulse);
      nsr    = (c == s1) || (c == s2);
      sample = (c == s2) ? v2 : v1;
    end
  endtask

  task automatic frame_check(input string tag, input int s1, input logic [N-1:0] v1,
                             input int s2, input logic [N-1:0] v2,
                             input logic [31:0] exp_bits, input int exp_ur, input int exp_ov);
    logic [31:0] bits;
    int sp, sp0, ur, ov, lrlow;
    run_frame(s1, v1, s2, v2, bits, sp, sp0, ur, ov, lrlow);
    check({tag, " bits"}, bits, exp_bits);
    check({tag, " pulse_count"}, sp, 1);
    check({tag, " pulse_at_start"}, sp0, 1);
    check({tag, " underruns"}, ur, exp_ur);
    check({tag, " overruns"}, ov, exp_ov);
    check({tag, " lrck_low_cycles"}, lrlow, FRAME / 2);
  endtask

`ifdef I2S_DELAY_EN
  localparam logic [31:0] F1 = 32'h52E1D2E1, F2 = 32'hD2E1D2E1, F4 = 32'h91111111;
  localparam logic [31:0] F5 = 32'h1E1E1E1E, F6 = 32'h2D2D2D2D, F7 = 32'h40004000;
`else
  localparam logic [31:0] F1 = 32'hA5C3A5C3, F2 = 32'hA5C3A5C3, F4 = 32'h22222222;
  localparam logic [31:0] F5 = 32'h3C3C3C3C, F6 = 32'h5A5A5A5A, F7 = 32'h80008000;
`endif

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, sampling_pulse, bclk, lrck, sdata, underrun, overrun}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    nsr = 1'b1; sample = 16'hA5C3;
    @(negedge clk);
    nsr = 1'b0; enable = 1'b1;

    frame_check("f1_first",    -1, '0,        -1, '0,        F1, 0, 0);
    frame_check("f2_repeat",   -1, '0,        -1, '0,        F2, 1, 0);
    frame_check("f3_double",   40, 16'h1111,  90, 16'h2222,  F2, 1, 1);
    frame_check("f4_coincide", 100, 16'h3C3C, 255, 16'h5A5A, F4, 0, 0);
    frame_check("f5_old_word", -1, '0,        -1, '0,        F5, 0, 0);
    frame_check("f6_new_word", 10, 16'h8000,  -1, '0,        F6, 0, 0);
    frame_check("f7_8000",     -1, '0,        -1, '0,        F7, 0, 0);
    nsr = 1'b0;

    repeat (37) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_link", {29'd0, bclk, lrck, sdata}, 32'd0);
    check("disable_pulse", {31'd0, sampling_pulse}, 32'd0);

    enable = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (c == 3001)
        check("midframe_reset", {26'd0, sampling_pulse, bclk, lrck, sdata, underrun, overrun}, 32'd0);
      nsr    = ($urandom_range(0, 149) == 0);
      sample = N'($urandom);
      if (c == 2900) enable = 1'b1;
      else if (c < 2900 || c > 3100) begin
        if ($urandom_range(0, 999) == 0) enable = ~enable;
      end
      reset = (c >= 3000 && c <= 3002);
    end
    nsr = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
